decode_ctrl_pipe: RTL and testbench
===================================

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 5, giving the ALU opcode width; it SHALL be at least 5.
REQ-002 SHALL have parameter EN_MEXT, default 1; when 1, RV32M instructions decode as legal.
REQ-003 SHALL have parameter EN_ILLEGAL, default 1; when 1, undecodable instructions raise ex_illegal.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 id_valid  in  1  ID stage holds an instruction.
REQ-008 id_inst  in  32  instruction word.
REQ-009 id_ready  out  1  ID instruction accepted this cycle.
REQ-010 ex_ready  in  1  EX stage consumes the current bundle.
REQ-011 flush  in  1  branch or jump redirect; kill ID and EX contents.
REQ-012 ex_valid  out  1  EX bundle valid.
REQ-013 ex_npc_op  out  2  next-PC select: 00 = pc+4, 01 = jalr, 10 = jal, 11 = branch.
REQ-014 ex_alub_sel  out  1  ALU operand-B select: 1 = immediate.
REQ-015 ex_alu_op  out  ALU_OP_W  ALU operation.
REQ-016 ex_wd_sel  out  2  writeback select: 00 = ALU, 01 = load, 10 = pc+4, 11 = auipc.
REQ-017 ex_dram_we, ex_rf_we, ex_is_load  out  1 each  store enable, register write enable, load flag.
REQ-018 ex_rd  out  5  destination register.
REQ-019 ex_illegal  out  1  illegal-instruction flag.
REQ-020 hz_stall  out  1  load-use stall asserted this cycle.

Function
- REQ-021 Decode SHALL be combinational on id_inst and registered into the EX bundle, giving 1-cycle latency from acceptance to ex_valid.
- REQ-022 Decode SHALL cover the following opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
- REQ-023 For LOAD, STORE, JALR and AUIPC, alu_op SHALL be ADD.
- REQ-024 For B-type instructions, alu_op SHALL be selected by funct3.
- REQ-025 For OP and OP-IMM instructions, alu_op SHALL be selected by funct3 plus bit 30; SRAI/SRLI SHALL be distinguished by bit 30.
- REQ-026 When EN_MEXT = 1, OP with funct7 = 0000001 SHALL decode to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU by funct3.
- REQ-027 ex_rf_we SHALL be forced to 0 when rd = x0, and for all S-type and B-type instructions.
- REQ-028 Illegal instructions SHALL be: an unknown opcode; bad funct7 on OP; funct3 ∈ {010, 011} on BRANCH; or M-extension instructions when EN_MEXT = 0.
- REQ-029 For an illegal instruction, the bundle SHALL load with ex_illegal = EN_ILLEGAL, ex_rf_we = 0, ex_dram_we = 0 and ex_npc_op = 00.
- REQ-030 Load-use hazard: when ex_valid and ex_is_load and ex_rd ≠ 0 and ex_rd matches a source actually read by id_inst (rs1 and/or rs2 per format), then hz_stall = 1 and id_ready = 0, and the register loads a bubble on ex_ready.
- REQ-031 Under a load-use hazard, the stall SHALL last exactly 1 cycle when ex_ready = 1.
- REQ-032 Bubble SHALL mean ex_valid = 0 with ex_rf_we, ex_dram_we, ex_is_load and ex_illegal all 0.
- REQ-033 When ex_ready = 0 and ex_valid = 1, the bundle SHALL hold and id_ready SHALL be 0.
- REQ-034 id_ready SHALL be !hz_stall && (ex_ready || !ex_valid).
- REQ-035 flush SHALL have top priority: next cycle the output is a bubble, regardless of stall, ex_ready or id_valid.
- REQ-036 During flush, hz_stall SHALL be 0.
- REQ-037 When id_valid = 0 and the register is free, a bubble SHALL load.

Reset
- REQ-038 On rst_n = 0, all outputs SHALL immediately become 0: ex_valid, ex_npc_op, ex_alub_sel, ex_alu_op, ex_wd_sel, ex_dram_we, ex_rf_we, ex_is_load, ex_rd and ex_illegal.
- REQ-039 hz_stall SHALL follow its combinational equation from the reset register state, and is therefore 0.
- REQ-040 Reset asserted mid-stall SHALL discard the pending instruction; the first cycle after deassertion SHALL accept normally.

Structure
- REQ-041 A shared package SHALL hold the opcode constants and the ALU opcode constants.
- REQ-042 The base ALU codes SHALL be: ADD = 0, SUB = 1, SLL = 2, XOR = 3, SRL = 4, SRA = 5, OR = 6, AND = 7, BLT_SLT = 8, SLTU = 9, BEQ = 10, BNE = 11, BGE = 12, BLTU = 13, BGEU = 14, LUI = 15.
- REQ-043 The M-extension codes SHALL be MUL = 16 through REMU = 23.
- REQ-044 The package SHALL also define the control-bundle struct.
- REQ-045 The combinational decoder SHALL be one sub-module, decode_ctrl_comb.
- REQ-046 The top level SHALL contain only the hazard logic and the pipeline register.

Verification
- REQ-047 0x002081B3 (add x3,x1,x2), id_valid = 1, ex_ready = 1 -> next cycle ex_valid = 1, ex_alu_op = 0, ex_rf_we = 1, ex_rd = 3, ex_alub_sel = 0, ex_wd_sel = 00.
- REQ-048 0x0000A283 (lw x5,0(x1)) then 0x00128333 (add x6,x5,x1) -> hz_stall = 1 for 1 cycle, then a bubble, then the add is issued with ex_rd = 6; with rd = x0 on the lw, no stall.
- REQ-049 0x022081B3 (mul) with EN_MEXT = 1 -> ex_alu_op = 16; with EN_MEXT = 0 -> ex_illegal = 1, ex_rf_we = 0.
- REQ-050 0x00000000 -> ex_illegal = 1, ex_dram_we = 0, ex_npc_op = 00.
- REQ-051 flush asserted together with a load-use stall and ex_ready = 0 -> next cycle ex_valid = 0 and hz_stall = 0.
- REQ-052 ex_ready held low for 3 cycles with a valid bundle -> outputs stable and id_ready = 0 throughout.
- REQ-053 rst_n pulsed low asynchronously mid-cycle -> outputs 0 before the next edge.

Source files
------------

// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared constants for the ID->EX decode pipeline: RV32 opcodes, ALU operation codes,
// next-PC / writeback selects and the registered control bundle.
package decode_ctrl_pipe_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam int unsigned AluCodeW = 5;
    typedef logic [AluCodeW-1:0] alu_code_t;

    localparam alu_code_t AluAdd    = 5'd0;
    localparam alu_code_t AluSub    = 5'd1;
    localparam alu_code_t AluSll    = 5'd2;
    localparam alu_code_t AluXor    = 5'd3;
    localparam alu_code_t AluSrl    = 5'd4;
    localparam alu_code_t AluSra    = 5'd5;
    localparam alu_code_t AluOr     = 5'd6;
    localparam alu_code_t AluAnd    = 5'd7;
    localparam alu_code_t AluBltSlt = 5'd8;
    localparam alu_code_t AluSltu   = 5'd9;
    localparam alu_code_t AluBeq    = 5'd10;
    localparam alu_code_t AluBne    = 5'd11;
    localparam alu_code_t AluBge    = 5'd12;
    localparam alu_code_t AluBltu   = 5'd13;
    localparam alu_code_t AluBgeu   = 5'd14;
    localparam alu_code_t AluLui    = 5'd15;
    localparam alu_code_t AluMul    = 5'd16;
    localparam alu_code_t AluMulh   = 5'd17;
    localparam alu_code_t AluMulhsu = 5'd18;
    localparam alu_code_t AluMulhu  = 5'd19;
    localparam alu_code_t AluDiv    = 5'd20;
    localparam alu_code_t AluDivu   = 5'd21;
    localparam alu_code_t AluRem    = 5'd22;
    localparam alu_code_t AluRemu   = 5'd23;

    localparam logic [1:0] NpcPc4    = 2'b00;
    localparam logic [1:0] NpcJalr   = 2'b01;
    localparam logic [1:0] NpcJal    = 2'b10;
    localparam logic [1:0] NpcBranch = 2'b11;

    localparam logic [1:0] WdAlu   = 2'b00;
    localparam logic [1:0] WdLoad  = 2'b01;
    localparam logic [1:0] WdPc4   = 2'b10;
    localparam logic [1:0] WdAuipc = 2'b11;

    typedef struct packed {
        logic [1:0] npc_op;
        logic       alub_sel;
        alu_code_t  alu_op;
        logic [1:0] wd_sel;
        logic       dram_we;
        logic       rf_we;
        logic       is_load;
        logic [4:0] rd;
        logic       illegal;
    } ctrl_t;

    // OP / OP-IMM mapping; alt selects SUB over ADD and SRA over SRL.
    function automatic alu_code_t base_alu_op(input logic [2:0] f3, input logic alt);
        alu_code_t op;
        unique case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluBltSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic alu_code_t mext_alu_op(input logic [2:0] f3);
        alu_code_t op;
        unique case (f3)
            3'b000:  op = AluMul;
            3'b001:  op = AluMulh;
            3'b010:  op = AluMulhsu;
            3'b011:  op = AluMulhu;
            3'b100:  op = AluDiv;
            3'b101:  op = AluDivu;
            3'b110:  op = AluRem;
            default: op = AluRemu;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Purely combinational RV32I(+M) instruction decoder producing the EX control bundle
// and the source registers the instruction actually reads.
module decode_ctrl_comb
    import decode_ctrl_pipe_pkg::*;
#(
    parameter bit EN_MEXT    = 1'b1,
    parameter bit EN_ILLEGAL = 1'b1
) (
    input  logic [31:0] inst_i,
    output ctrl_t       ctrl_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic       illegal;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign f3     = inst_i[14:12];
    assign rs1_o  = inst_i[19:15];
    assign rs2_o  = inst_i[24:20];
    assign f7     = inst_i[31:25];

    always_comb begin
        ctrl_o     = '0;
        rs1_used_o = 1'b0;
        rs2_used_o = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OpcLui: begin
                ctrl_o.alub_sel = 1'b1;
                ctrl_o.alu_op   = AluLui;
                ctrl_o.rf_we    = 1'b1;
                ctrl_o.rd       = rd;
            end
            OpcAuipc: begin
                ctrl_o.alub_sel = 1'b1;
                ctrl_o.wd_sel   = WdAuipc;
                ctrl_o.rf_we    = 1'b1;
                ctrl_o.rd       = rd;
            end
            OpcJal: begin
                ctrl_o.npc_op = NpcJal;
                ctrl_o.wd_sel = WdPc4;
                ctrl_o.rf_we  = 1'b1;
                ctrl_o.rd     = rd;
            end
            OpcJalr: begin
                ctrl_o.npc_op   = NpcJalr;
                ctrl_o.alub_sel = 1'b1;
                ctrl_o.wd_sel   = WdPc4;
                ctrl_o.rf_we    = 1'b1;
                ctrl_o.rd       = rd;
                rs1_used_o      = 1'b1;
            end
            OpcBranch: begin
                ctrl_o.npc_op = NpcBranch;
                rs1_used_o    = 1'b1;
                rs2_used_o    = 1'b1;
                case (f3)
                    3'b000:  ctrl_o.alu_op = AluBeq;
                    3'b001:  ctrl_o.alu_op = AluBne;
                    3'b100:  ctrl_o.alu_op = AluBltSlt;
                    3'b101:  ctrl_o.alu_op = AluBge;
                    3'b110:  ctrl_o.alu_op = AluBltu;
                    3'b111:  ctrl_o.alu_op = AluBgeu;
                    default: illegal       = 1'b1;
                endcase
            end
            OpcLoad: begin
                ctrl_o.alub_sel = 1'b1;
                ctrl_o.wd_sel   = WdLoad;
                ctrl_o.is_load  = 1'b1;
                ctrl_o.rf_we    = 1'b1;
                ctrl_o.rd       = rd;
                rs1_used_o      = 1'b1;
            end
            OpcStore: begin
                ctrl_o.alub_sel = 1'b1;
                ctrl_o.dram_we  = 1'b1;
                rs1_used_o      = 1'b1;
                rs2_used_o      = 1'b1;
            end
            OpcOpImm: begin
                // Bit 30 is immediate data for ADDI, so only shifts honour it.
                ctrl_o.alub_sel = 1'b1;
                ctrl_o.alu_op   = base_alu_op(f3, inst_i[30] && (f3 == 3'b101));
                ctrl_o.rf_we    = 1'b1;
                ctrl_o.rd       = rd;
                rs1_used_o      = 1'b1;
            end
            OpcOp: begin
                ctrl_o.rf_we = 1'b1;
                ctrl_o.rd    = rd;
                rs1_used_o   = 1'b1;
                rs2_used_o   = 1'b1;
                case (f7)
                    7'b0000000: ctrl_o.alu_op = base_alu_op(f3, 1'b0);
                    7'b0100000: begin
                        if (f3 == 3'b000 || f3 == 3'b101) begin
                            ctrl_o.alu_op = base_alu_op(f3, 1'b1);
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        if (EN_MEXT) begin
                            ctrl_o.alu_op = mext_alu_op(f3);
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        if (ctrl_o.rd == 5'd0) begin
            ctrl_o.rf_we = 1'b0;
        end
        if (illegal) begin
            ctrl_o.illegal = EN_ILLEGAL;
            ctrl_o.rf_we   = 1'b0;
            ctrl_o.dram_we = 1'b0;
            ctrl_o.is_load = 1'b0;
            ctrl_o.npc_op  = NpcPc4;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID->EX pipeline register with load-use hazard detection, back-pressure and flush.
// Decode itself lives in decode_ctrl_comb.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int unsigned ALU_OP_W   = 5,
    parameter bit          EN_MEXT    = 1'b1,
    parameter bit          EN_ILLEGAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [31:0]         id_inst,
    output logic                id_ready,
    input  logic                ex_ready,
    input  logic                flush,
    output logic                ex_valid,
    output logic [1:0]          ex_npc_op,
    output logic                ex_alub_sel,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [1:0]          ex_wd_sel,
    output logic                ex_dram_we,
    output logic                ex_rf_we,
    output logic                ex_is_load,
    output logic [4:0]          ex_rd,
    output logic                ex_illegal,
    output logic                hz_stall
);

    ctrl_t      dec_ctrl;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       load_use;
    logic       valid_q, valid_d;
    ctrl_t      ex_q, ex_d;

    decode_ctrl_comb #(
        .EN_MEXT   (EN_MEXT),
        .EN_ILLEGAL(EN_ILLEGAL)
    ) u_decode (
        .inst_i    (id_inst),
        .ctrl_o    (dec_ctrl),
        .rs1_o     (rs1),
        .rs2_o     (rs2),
        .rs1_used_o(rs1_used),
        .rs2_used_o(rs2_used)
    );

    assign load_use = valid_q && ex_q.is_load && (ex_q.rd != 5'd0) && id_valid &&
                      ((rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd)));
    assign hz_stall = load_use && !flush;
    assign id_ready = !hz_stall && (ex_ready || !valid_q);

    // Flush beats everything; otherwise a free register takes the decode or a bubble.
    always_comb begin
        valid_d = valid_q;
        ex_d    = ex_q;
        if (flush) begin
            valid_d = 1'b0;
            ex_d    = '0;
        end else if (ex_ready || !valid_q) begin
            if (id_valid && !hz_stall) begin
                valid_d = 1'b1;
                ex_d    = dec_ctrl;
            end else begin
                valid_d = 1'b0;
                ex_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ex_q    <= ex_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_npc_op   = ex_q.npc_op;
    assign ex_alub_sel = ex_q.alub_sel;
    assign ex_alu_op   = ALU_OP_W'(ex_q.alu_op);
    assign ex_wd_sel   = ex_q.wd_sel;
    assign ex_dram_we  = ex_q.dram_we;
    assign ex_rf_we    = ex_q.rf_we;
    assign ex_is_load  = ex_q.is_load;
    assign ex_rd       = ex_q.rd;
    assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: the driver queues hand-computed bundles on
// acceptance, a monitor pops and compares whenever EX presents a consumed bundle.
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_inst = 32'h0;
    logic        ex_ready = 1'b0;
    logic        flush = 1'b0;

    logic        id_ready, ex_valid, ex_alub_sel, ex_dram_we, ex_rf_we, ex_is_load;
    logic        ex_illegal, hz_stall;
    logic [1:0]  ex_npc_op, ex_wd_sel;
    logic [4:0]  ex_alu_op, ex_rd;

    logic        nm_id_ready, nm_ex_valid, nm_alub_sel, nm_dram_we, nm_rf_we, nm_is_load;
    logic        nm_illegal, nm_hz_stall;
    logic [1:0]  nm_npc_op, nm_wd_sel;
    logic [4:0]  nm_alu_op, nm_rd;

    always #10 clk = ~clk;

    decode_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
        .ex_npc_op(ex_npc_op), .ex_alub_sel(ex_alub_sel), .ex_alu_op(ex_alu_op),
        .ex_wd_sel(ex_wd_sel), .ex_dram_we(ex_dram_we), .ex_rf_we(ex_rf_we),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .hz_stall(hz_stall)
    );

    decode_ctrl_pipe #(.EN_MEXT(1'b0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .id_ready(nm_id_ready), .ex_ready(ex_ready), .flush(flush), .ex_valid(nm_ex_valid),
        .ex_npc_op(nm_npc_op), .ex_alub_sel(nm_alub_sel), .ex_alu_op(nm_alu_op),
        .ex_wd_sel(nm_wd_sel), .ex_dram_we(nm_dram_we), .ex_rf_we(nm_rf_we),
        .ex_is_load(nm_is_load), .ex_rd(nm_rd), .ex_illegal(nm_illegal),
        .hz_stall(nm_hz_stall)
    );

    typedef struct packed {
        logic [1:0] npc;
        logic       alub;
        logic [4:0] alu;
        logic [1:0] wd;
        logic       dwe;
        logic       rfwe;
        logic       ld;
        logic [4:0] rd;
        logic       ill;
        logic       nm_ill;  // also expect the no-M instance to flag this one illegal
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic exp_t mk(int npc, int alub, int alu, int wd, int dwe, int rfwe,
                                int ld, int rd, int ill, int nm);
        exp_t e;
        e.npc = 2'(npc);  e.alub = 1'(alub); e.alu = 5'(alu); e.wd = 2'(wd);
        e.dwe = 1'(dwe);  e.rfwe = 1'(rfwe); e.ld = 1'(ld);   e.rd = 5'(rd);
        e.ill = 1'(ill);  e.nm_ill = 1'(nm);
        return e;
    endfunction

    function automatic logic [18:0] act_bundle();
        return {ex_npc_op, ex_alub_sel, ex_alu_op, ex_wd_sel, ex_dram_we, ex_rf_we,
                ex_is_load, ex_rd, ex_illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present inst from the next negedge until accepted; queue its expected bundle.
    task automatic issue(input logic [31:0] inst, input exp_t e, output int waits);
        @(negedge clk);
        #1;
        id_valid = 1'b1;
        id_inst  = inst;
        waits    = 0;
        #1;
        while (!id_ready && waits < 20) begin
            waits++;
            @(negedge clk);
            #2;
        end
        if (!id_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: inst 0x%08h never accepted", inst);
        end else begin
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    // Monitor: a bundle leaving EX (consumed or flushed) is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (ex_valid && (ex_ready || flush)) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_bundle: got 0x%0h with empty queue", act_bundle());
                end else begin
                    e = q.pop_front();
                    check("bundle", 32'(act_bundle()), 32'(e[19:1]));
                    if (e.nm_ill) check("nomext_illegal", 32'({nm_illegal, nm_rf_we}), 32'h2);
                end
            end else if (!ex_valid) begin
                check("bubble", 32'({ex_rf_we, ex_dram_we, ex_is_load, ex_illegal}), 32'h0);
            end
        end
    end

    initial begin
        int   w;
        exp_t e_add3, e_lw5, e_add6;
        e_add3 = mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 0);
        e_lw5  = mk(0, 1, 0, 1, 0, 1, 1, 5, 0, 0);
        e_add6 = mk(0, 0, 0, 0, 0, 1, 0, 6, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({ex_valid, act_bundle()}), 32'h0);
        check("rst_hz_stall", 32'(hz_stall), 32'h0);
        #1;
        rst_n    = 1'b1;
        ex_ready = 1'b1;

        // Back-to-back decode of distinct formats.
        issue(32'h002081B3, e_add3, w);                                   // add x3,x1,x2
        issue(32'h40208233, mk(0, 0, 1, 0, 0, 1, 0, 4, 0, 0), w);         // sub x4
        issue(32'h4030D393, mk(0, 1, 5, 0, 0, 1, 0, 7, 0, 0), w);         // srai x7
        issue(32'h0030D393, mk(0, 1, 4, 0, 0, 1, 0, 7, 0, 0), w);         // srli x7
        issue(32'h00208463, mk(3, 0, 10, 0, 0, 0, 0, 0, 0, 0), w);        // beq
        issue(32'h0020A223, mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0), w);         // sw
        issue(32'h123452B7, mk(0, 1, 15, 0, 0, 1, 0, 5, 0, 0), w);        // lui x5
        issue(32'h010000EF, mk(2, 0, 0, 2, 0, 1, 0, 1, 0, 0), w);         // jal x1
        issue(32'h00008067, mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 0), w);         // jalr x0
        issue(32'h00001517, mk(0, 1, 0, 3, 0, 1, 0, 10, 0, 0), w);        // auipc x10
        issue(32'h022081B3, mk(0, 0, 16, 0, 0, 1, 0, 3, 0, 1), w);        // mul x3
        issue(32'h0220D1B3, mk(0, 0, 21, 0, 0, 1, 0, 3, 0, 1), w);        // divu x3
        issue(32'h00000000, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), w);         // all-zero word
        issue(32'h0020A463, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), w);         // branch f3=010
        idle();

        // Load-use on rs1: one stall cycle, then a bubble, then the add.
        issue(32'h0000A283, e_lw5, w);
        @(negedge clk);
        #1;
        id_inst = 32'h00128333;
        #1;
        check("lu_stall", 32'({hz_stall, id_ready}), 32'h2);
        @(negedge clk);
        #2;
        check("lu_release", 32'({hz_stall, id_ready, ex_valid}), 32'h2);
        q.push_back(e_add6);
        idle();

        // Load-use on rs2 (store data) and no hazard when the load targets x0.
        issue(32'h0000A283, e_lw5, w);
        issue(32'h0050A223, mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0), w);
        check("lu_rs2_waits", 32'(w), 32'd1);
        issue(32'h0000A003, mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 0), w);
        issue(32'h00100333, e_add6, w);
        check("lu_x0_waits", 32'(w), 32'd0);
        idle();

        // Back-pressure: bundle holds three cycles with id_ready low.
        issue(32'h002081B3, e_add3, w);
        @(negedge clk);
        #1;
        ex_ready = 1'b0;
        id_inst  = 32'h40208233;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_id_ready", 32'(id_ready), 32'h0);
            check("hold_bundle", 32'({ex_valid, act_bundle()}), 32'({1'b1, e_add3[19:1]}));
            @(negedge clk);
            #1;
        end
        ex_ready = 1'b1;
        #1;
        check("hold_release", 32'(id_ready), 32'h1);
        q.push_back(mk(0, 0, 1, 0, 0, 1, 0, 4, 0, 0));
        idle();

        // Flush together with a load-use stall and ex_ready low.
        issue(32'h0000A283, e_lw5, w);
        @(negedge clk);
        #1;
        id_inst  = 32'h00128333;
        ex_ready = 1'b0;
        flush    = 1'b1;
        #1;
        check("flush_no_stall", 32'(hz_stall), 32'h0);
        @(negedge clk);
        #1;
        flush    = 1'b0;
        ex_ready = 1'b1;
        id_valid = 1'b0;
        #1;
        check("flush_bubble", 32'({ex_valid, hz_stall}), 32'h0);

        // Asynchronous reset mid-stall discards the pending add.
        issue(32'h0000A283, e_lw5, w);
        @(negedge clk);
        #1;
        id_inst = 32'h00128333;
        #1;
        check("rst_pre_stall", 32'(hz_stall), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 32'({ex_valid, act_bundle()}), 32'h0);
        check("rst_async_stall", 32'(hz_stall), 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_accept", 32'(id_ready), 32'h1);
        q.push_back(e_add6);
        idle();

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
